// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: shared types and helpers for the 1-D CNN datapath.
//   relu_mask_t                  - one ReLU derivative bit per sample
//   relu_deriv(data)             - derivative bit of a sign-extended sample
//   RELU_BWD_DEFAULT_LEAK_SHIFT  - default leaky slope exponent (2^-3)
package cnn1d_pkg;

  localparam int RELU_BWD_DEFAULT_LEAK_SHIFT = 3;

  typedef logic relu_mask_t;

  // Callers sign-extend their sample to 64 bits; sign and "non-zero" survive
  // the extension, so one function serves every data width up to 64.
  // Returns 1 for x > 0, 0 for x <= 0.
  function automatic relu_mask_t relu_deriv(input logic [63:0] data);
    return ~data[63] & (|data);
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// relu_mask_fifo: 1-bit-wide synchronous FIFO holding ReLU derivative bits.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_bit    write strobe and bit (ignored when full or flushing)
//   pop, pop_bit      read strobe (ignored when empty or flushing), head bit
//   flush             synchronous clear of pointers and count
//   count/full/empty  registered occupancy, valid after each edge
// Full/empty come from the occupancy counter, not a pointer compare, so the
// pointers are plain log2(DEPTH)-bit wrap-around counters.
module relu_mask_fifo
  import cnn1d_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  relu_mask_t                 push_bit,
  input  logic                       pop,
  output relu_mask_t                 pop_bit,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  relu_mask_t [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] next_count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign pop_bit = mem[rd_ptr];

  always_comb begin
    next_count = count;
    case ({do_push, do_pop})
      2'b10:   next_count = count + CW'(1);
      2'b01:   next_count = count - CW'(1);
      default: next_count = count;
    endcase
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= next_count;
      full  <= (next_count == CW'(DEPTH));
      empty <= (next_count == '0);
    end
  end

endmodule

// File: rtl/relu_backward.sv
// relu_backward: backward pass of a ReLU stage.
// The forward tap records one derivative bit per pre-activation sample
// (1 for x>0) in a mask FIFO; the backward path gates each incoming
// gradient with the oldest stored bit and registers the result.
// Ports:
//   clk, rst                                  clock, async active-low reset
//   fwd_valid_in/fwd_ready_in/fwd_data_in     forward tap
//   grad_valid_in/grad_ready_in/grad_data_in  upstream gradient
//   grad_valid_out/grad_ready_out/grad_data_out  gated gradient (1 reg stage)
//   mask_flush                                synchronous clear of mask FIFO
//   mask_count/mask_full/mask_empty           registered FIFO status
// Build option: RELU_BWD_LEAKY_EN makes masked gradients grad >>> LEAK_SHIFT
// (leaky-ReLU derivative) instead of zero.
//
// Handshakes: a transfer happens on an edge where valid & ready are both 1;
// a valid source holds data stable until that edge, and ready never depends
// on the same interface's valid. There is no bypass: a bit pushed this cycle
// is poppable next cycle at the earliest, and a full FIFO refuses a push
// even when a pop frees a slot in the same cycle.
module relu_backward
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int MASK_DEPTH = 64,
  parameter int LEAK_SHIFT = RELU_BWD_DEFAULT_LEAK_SHIFT
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            fwd_ready_in,
  input  logic                            fwd_valid_in,
  input  logic [DATA_WIDTH-1:0]           fwd_data_in,
  output logic                            grad_ready_in,
  input  logic                            grad_valid_in,
  input  logic [DATA_WIDTH-1:0]           grad_data_in,
  input  logic                            grad_ready_out,
  output logic                            grad_valid_out,
  output logic [DATA_WIDTH-1:0]           grad_data_out,
  input  logic                            mask_flush,
  output logic [$clog2(MASK_DEPTH+1)-1:0] mask_count,
  output logic                            mask_full,
  output logic                            mask_empty
);

`ifdef RELU_BWD_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  logic                  stage_free;
  logic                  push;
  logic                  pop;
  relu_mask_t            push_bit;
  relu_mask_t            pop_bit;
  logic [DATA_WIDTH-1:0] leak_grad;
  logic [DATA_WIDTH-1:0] masked_grad;
  logic [DATA_WIDTH-1:0] gated_grad;

  assign stage_free    = grad_ready_out | ~grad_valid_out;
  assign fwd_ready_in  = ~mask_full & ~mask_flush;
  assign grad_ready_in = stage_free & ~mask_empty & ~mask_flush;
  assign push          = fwd_valid_in & fwd_ready_in;
  assign pop           = grad_valid_in & grad_ready_in;

  assign push_bit = relu_deriv({{(64-DATA_WIDTH){fwd_data_in[DATA_WIDTH-1]}}, fwd_data_in});

  // The leak path is a constant-selected mux; in the non-leaky build it
  // folds away and masked gradients are zero.
  assign leak_grad   = $signed(grad_data_in) >>> LEAK_SHIFT;
  assign masked_grad = LEAKY ? leak_grad : '0;
  assign gated_grad  = pop_bit ? grad_data_in : masked_grad;

  relu_mask_fifo #(
    .DEPTH (MASK_DEPTH)
  ) u_mask_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_bit (push_bit),
    .pop      (pop),
    .pop_bit  (pop_bit),
    .flush    (mask_flush),
    .count    (mask_count),
    .full     (mask_full),
    .empty    (mask_empty)
  );

  // Output register: load on pop, drop valid once the beat is taken,
  // hold everything while stalled. Flush does not touch this stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grad_valid_out <= 1'b0;
      grad_data_out  <= '0;
    end else if (pop) begin
      grad_valid_out <= 1'b1;
      grad_data_out  <= gated_grad;
    end else if (stage_free) begin
      grad_valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/relu_backward.md
Name: relu_backward

Overview:
- Backward-pass counterpart of the ReLU activation stage.
- During the forward pass it taps the pre-activation stream and records one derivative bit per sample in a mask FIFO. The bit is 1 if x>0 and 0 if x<=0.
- During the backward pass it gates the incoming gradient stream with those bits, in FIFO order. Gated gradient = grad if bit=1, else 0.
- Sits between the next layer's gradient output and the previous layer's gradient input, with AXI-stream-style valid/ready on every interface.

Parameters:
- DATA_WIDTH, 12, width of pre-activation and gradient samples (two's complement).
- MASK_DEPTH, 64, mask FIFO entries; power of two, >=2.
- LEAK_SHIFT, 3, arithmetic right-shift for masked gradients; only used with RELU_BWD_LEAKY_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- fwd_ready_in  out  1  forward tap ready
- fwd_valid_in  in  1  forward tap valid
- fwd_data_in  in  DATA_WIDTH  pre-activation sample
- grad_ready_in  out  1  gradient input ready
- grad_valid_in  in  1  gradient input valid
- grad_data_in  in  DATA_WIDTH  upstream gradient
- grad_ready_out  in  1  downstream ready
- grad_valid_out  out  1  gated gradient valid
- grad_data_out  out  DATA_WIDTH  gated gradient
- mask_flush  in  1  synchronous clear of mask FIFO
- mask_count  out  $clog2(MASK_DEPTH+1)  stored mask bits
- mask_full  out  1  mask_count==MASK_DEPTH
- mask_empty  out  1  mask_count==0

Behaviour:
- Reset (rst low, asynchronous assert, synchronous deassert at the block boundary): grad_valid_out=0, grad_data_out=0, mask_count=0, mask_empty=1, mask_full=0, FIFO pointers=0. Reset mid-operation discards all stored bits and any in-flight output.
- Forward push:
  - fwd_ready_in = ~mask_full & ~mask_flush.
  - Push when fwd_valid_in & fwd_ready_in.
  - Pushed bit = ~fwd_data_in[DATA_WIDTH-1] & (|fwd_data_in). Zero yields 0.
- Output stage:
  - One register stage, latency 1 cycle from gradient acceptance to grad_valid_out.
  - stage_free = grad_ready_out | ~grad_valid_out.
  - grad_ready_in = stage_free & ~mask_empty & ~mask_flush.
- Backward pop: on grad_valid_in & grad_ready_in, pop one bit and load grad_data_out. Bit=1 loads grad_data_in; bit=0 loads 0. Set grad_valid_out=1.
  - If stage_free and no pop, grad_valid_out<=0.
  - If ~stage_free, hold grad_valid_out and grad_data_out stable.
- No bypass:
  - A bit pushed in cycle N is poppable from N+1 at the earliest.
  - When empty, grad_ready_in=0 even if fwd_valid_in=1 in the same cycle.
  - When full, pops are still allowed, but a push in the same cycle is blocked (fwd_ready_in sampled on the full flag). The count drops by 1.
- Simultaneous push and pop when neither full nor empty: count unchanged, both pointers advance.
- Pointers: log2(MASK_DEPTH) bits each, natural wrap-around. Full/empty derive from mask_count, not pointer compare.
- mask_flush=1:
  - Next edge clears pointers and count.
  - Blocks push and pop that cycle (both readies 0).
  - Output register is untouched; an already-valid beat still completes normally.
- mask_count, mask_full and mask_empty are registered and reflect the post-edge state.

Optional Feature:
- Macro RELU_BWD_LEAKY_EN.
- Defined: bit=0 gradients output grad_data_in >>> LEAK_SHIFT (arithmetic, sign-preserving, truncating toward -inf) instead of 0. This is the leaky-ReLU derivative with slope 2^-LEAK_SHIFT.
- Undefined: bit=0 outputs 0, and LEAK_SHIFT is unused.

Decomposition:
- Shared package cnn1d_pkg gains:
  - a relu_mask_t typedef (1-bit logic).
  - a function relu_deriv(data) returning the mask bit.
  - constant RELU_BWD_DEFAULT_LEAK_SHIFT=3.
- Sub-module relu_mask_fifo (1-bit-wide synchronous FIFO with count/full/empty/flush, parameter DEPTH), instantiated once.
- The top level holds handshake logic and the output register.

Test Plan:
- Push fwd 12'h005, 12'hFFB, 12'h000, 12'h7FF, then grads 12'h010 x4 with grad_ready_out=1. Outputs 12'h010, 0, 0, 12'h010, each one cycle after acceptance; mask_count returns 0.
- Push 64 positive samples. mask_full=1, fwd_ready_in=0 on the 65th. Then one grad pop plus a fwd push in the same cycle: push refused, mask_count=63.
- grad_valid_in=1 with empty FIFO and fwd push in the same cycle: grad_ready_in=0 that cycle, 1 the next. Output gradient passed through.
- Backpressure: grad_ready_out=0 for 5 cycles with an output beat valid. grad_data_out stable, grad_ready_in=0, FIFO count unchanged; beat drains when ready returns.
- Push 10 bits, assert mask_flush one cycle while an output beat is pending. mask_count=0 next cycle, pending beat still delivered. Assert rst low mid-stream: grad_valid_out=0 and mask_empty=1 immediately.
- RELU_BWD_LEAKY_EN defined, LEAK_SHIFT=3. Mask bit 0 with grad 12'hFF0 (-16) outputs 12'hFFE (-2); grad 12'h020 outputs 12'h004.
